// File: rtl/alu_logic_pkg.sv
// Shared definitions for the arbitrated bitwise logic unit.
package alu_logic_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic [1:0] grant_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_logic_arbiter_if.sv
// Request/result bundle between the issue logic (master) and the shared logic unit (slave).
interface alu_logic_arbiter_if #(
  parameter int unsigned WIDTH = alu_logic_pkg::WIDTH_DEF
) ();

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_op0;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [1:0]       req_op1;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             out_zero;
  logic             busy;

  modport master (
    output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_zero, busy
  );

  modport slave (
    input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, out_ready,
    output req_ready, out_valid, out_data, out_id, out_zero, busy
  );

endinterface

// File: rtl/alu_logic_arbiter_logic_unit.sv
// Combinational bitwise AND/OR/XOR/NAND slice, one gate set per bit.
module logic_unit
  import alu_logic_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign w_and[g] = i_a[g] & i_b[g];
    assign w_or[g]  = i_a[g] | i_b[g];
    assign w_xor[g] = i_a[g] ^ i_b[g];
    // op[1] picks the XOR/NAND pair, op[0] the second member of each pair.
    assign o_y[g]   = i_op[1] ? (i_op[0] ? ~w_and[g] : w_xor[g])
                              : (i_op[0] ?  w_or[g]  : w_and[g]);
  end

endmodule

// File: rtl/alu_logic_arbiter.sv
// Round-robin share of one logic unit between two requesters; one operation in flight at a time.
module alu_logic_arbiter
  import alu_logic_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  alu_logic_arbiter_if.slave bus
);

  state_e           r_state;
  logic             r_last_grant;
  logic             r_id;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_id;
  logic             r_out_zero;
  logic             r_busy;

  logic             w_accept;
  logic             w_grant_id;
  logic [1:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_y;

  // On a tie the requester that did not own the last handed-off result wins.
  assign w_grant_id = (&bus.req_valid) ? ~r_last_grant : bus.req_valid[1];
  assign w_accept   = (r_state == IDLE) && (|bus.req_valid) && !rst;

  assign bus.req_ready = w_accept ? grant_onehot(w_grant_id) : 2'b00;

  assign w_sel_op = w_grant_id ? bus.req_op1 : bus.req_op0;
  assign w_sel_a  = w_grant_id ? bus.req_a1  : bus.req_a0;
  assign w_sel_b  = w_grant_id ? bus.req_b1  : bus.req_b0;

  logic_unit #(
    .WIDTH(WIDTH)
  ) u_logic_unit (
    .i_op(r_op),
    .i_a (r_a),
    .i_b (r_b),
    .o_y (w_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_op         <= 2'b00;
      r_a          <= '0;
      r_b          <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_id     <= 1'b0;
      r_out_zero   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= w_sel_op;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_id    <= w_grant_id;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_out_data  <= w_y;
          r_out_zero  <= (w_y == '0);
          r_out_id    <= r_id;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          // Fairness pointer moves on handoff only, so a stalled result keeps its priority slot.
          if (bus.out_ready) begin
            r_last_grant <= r_id;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;
  assign bus.out_zero  = r_out_zero;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Vector table plus scoreboard bench for the shared logic-unit arbiter.
module tb_alu_logic_arbiter;
  import alu_logic_pkg::*;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_logic_arbiter_if #(.WIDTH(W)) bus ();

  alu_logic_arbiter #(
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  op0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [1:0]  op1;
    logic [15:0] a1;
    logic [15:0] b1;
    bit          keep;
    bit          scramble;
    bit          rst_before;
    int          stall;
    logic        exp_id;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] data;
  } res_t;

  vec_t vecs[$];
  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_hs = 0;
  int   n_hs_exp = 0;
  logic lg;

  always @(negedge clk) if (!rst && bus.out_valid && bus.out_ready) n_hs++;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] op0,
                              input logic [15:0] a0, input logic [15:0] b0,
                              input logic [1:0] op1, input logic [15:0] a1,
                              input logic [15:0] b1, input bit keep, input bit scr,
                              input bit rb, input int stall, input logic id,
                              input logic [15:0] data);
    vec_t v;
    v.valid = valid; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.keep = keep; v.scramble = scr; v.rst_before = rb; v.stall = stall;
    v.exp_id = id; v.exp_data = data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    bus.req_valid = 2'b00;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #3;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_id",    32'(bus.out_id),    32'd0);
    chk("rst_out_zero",  32'(bus.out_zero),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lg = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid = v.valid;
    bus.req_op0 = v.op0; bus.req_a0 = v.a0; bus.req_b0 = v.b0;
    bus.req_op1 = v.op1; bus.req_a1 = v.a1; bus.req_b1 = v.b1;
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the handoff edge.
  task automatic run_vec(input vec_t v);
    res_t       r;
    res_t       got;
    logic [1:0] exp_rdy;
    int         cnt;
    exp_rdy = (v.valid == 2'b11) ? (lg ? 2'b01 : 2'b10) : v.valid;
    drive_req(v);
    @(negedge clk);
    chk("grant_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("idle_busy", 32'(bus.busy), 32'd0);
    r.id = v.exp_id;
    r.data = v.exp_data;
    sb.push_back(r);
    n_hs_exp++;
    @(posedge clk);
    #1;
    if (!v.keep) bus.req_valid = 2'b00;
    if (v.scramble) begin
      bus.req_a0 = ~v.a0; bus.req_b0 = ~v.b0;
      bus.req_a1 = ~v.a1; bus.req_b1 = ~v.b1;
    end
    bus.out_ready = (v.stall == 0);
    @(negedge clk);
    chk("exec_ready", 32'(bus.req_ready), 32'd0);
    chk("exec_valid", 32'(bus.out_valid), 32'd0);
    chk("exec_busy",  32'(bus.busy),      32'd1);
    @(negedge clk);
    chk("latency_valid", 32'(bus.out_valid), 32'd1);
    cnt = 0;
    while (!bus.out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    if (!bus.out_valid) begin
      got = sb.pop_front();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      return;
    end
    for (int k = 0; k < v.stall; k++) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data",  32'(bus.out_data),  32'(v.exp_data));
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      if (k == v.stall - 1) bus.out_ready = 1'b1;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk("out_data", 32'(bus.out_data), 32'(got.data));
      chk("out_id",   32'(bus.out_id),   32'(got.id));
      chk("out_zero", 32'(bus.out_zero), 32'(got.data == 16'h0000));
    end
    @(posedge clk);
    #1;
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_busy",  32'(bus.busy),      32'd0);
    lg = v.exp_id;
  endtask

  // Accept a req0 operation, then reset during EXEC (in_done=0) or DONE (in_done=1).
  task automatic abort_op(input bit in_done);
    vec_t v;
    v = mk(2'b01, OP_OR, 16'h1234, 16'h0001, OP_AND, 16'h0, 16'h0, 0, 0, 0, 0, 1'b0, 16'h1235);
    drive_req(v);
    @(negedge clk);
    chk("abort_grant", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    bus.out_ready = 1'b0;
    if (in_done) begin
      @(posedge clk);
      #1;
      chk("abort_pre_valid", 32'(bus.out_valid), 32'd1);
      chk("abort_pre_data",  32'(bus.out_data),  32'h1235);
    end else begin
      chk("abort_pre_busy", 32'(bus.busy), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy",  32'(bus.busy),      32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd0);
    chk("abort_data",  32'(bus.out_data),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lg = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    logic        lg_fill;
    logic [1:0]  rv;
    logic [1:0]  o0;
    logic [1:0]  o1;
    logic [15:0] ra0, rb0, ra1, rb1;
    logic        id;

    bus.req_valid = 2'b00;
    bus.req_op0 = 2'b00; bus.req_a0 = '0; bus.req_b0 = '0;
    bus.req_op1 = 2'b00; bus.req_a1 = '0; bus.req_b1 = '0;
    bus.out_ready = 1'b0;
    apply_reset();

    lg_fill = 1'b1;
    vecs.push_back(mk(2'b01, OP_AND, 16'h48DB, 16'h5168, OP_AND, 16'h0, 16'h0,
                      0, 0, 0, 0, 1'b0, 16'h4048));
    lg_fill = 1'b0;
    for (int i = 0; i < 4; i++) begin
      id = i[0];
      vecs.push_back(mk(2'b11, OP_OR, 16'hFF00, 16'h0F0F, OP_XOR, 16'hAAAA, 16'hFFFF,
                        (i < 3), 0, (i == 0), 0, id, id ? 16'h5555 : 16'hFF0F));
    end
    lg_fill = 1'b1;
    vecs.push_back(mk(2'b10, OP_AND, 16'h0, 16'h0, OP_NAND, 16'hFFFF, 16'hFFFF,
                      0, 0, 0, 5, 1'b1, 16'h0000));
    vecs.push_back(mk(2'b01, OP_XOR, 16'h1234, 16'h00FF, OP_AND, 16'h0, 16'h0,
                      0, 1, 0, 0, 1'b0, 16'h12CB));
    lg_fill = 1'b0;
    for (int op = 0; op < 4; op++) begin
      for (int k = 0; k < 3; k++) begin
        rv  = 2'($urandom_range(1, 3));
        o0  = 2'(op);
        o1  = 2'(3 - op);
        ra0 = 16'($urandom); rb0 = 16'($urandom);
        ra1 = 16'($urandom); rb1 = 16'($urandom);
        id  = (rv == 2'b11) ? ~lg_fill : rv[1];
        vecs.push_back(mk(rv, o0, ra0, rb0, o1, ra1, rb1, 0, (k == 1), 0, k, id,
                          id ? ref_op(o1, ra1, rb1) : ref_op(o0, ra0, rb0)));
        lg_fill = id;
      end
    end

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) apply_reset();
      run_vec(vecs[i]);
    end

    // Leave last_grant at 0, abort in EXEC, and expect a tie to go to requester 0 again.
    run_vec(mk(2'b01, OP_AND, 16'hF0F0, 16'h3C3C, OP_AND, 16'h0, 16'h0,
               0, 0, 0, 0, 1'b0, 16'h3030));
    abort_op(1'b0);
    run_vec(mk(2'b11, OP_NAND, 16'h00FF, 16'h0F0F, OP_OR, 16'h1111, 16'h2222,
               0, 0, 0, 0, 1'b0, 16'hFFF0));
    abort_op(1'b1);
    run_vec(mk(2'b10, OP_AND, 16'h0, 16'h0, OP_OR, 16'h1111, 16'h2222,
               0, 0, 0, 0, 1'b1, 16'h3333));

    @(negedge clk);
    chk("handshake_count", 32'(n_hs), 32'(n_hs_exp));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
